// File: rtl/riscv_nn_instr_l0_buffer_if.sv
// rtl/riscv_nn_instr_l0_buffer_if.sv - fetch-side and memory-side handshake bundle of the L0 instruction buffer
interface riscv_nn_instr_l0_buffer_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  // slave: the buffer itself; master: prefetcher plus instruction memory around it
  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/riscv_nn_instr_l0_buffer.sv
// rtl/riscv_nn_instr_l0_buffer.sv - single-line L0 instruction buffer with linear line refill
// NN_L0_PERF_CNT_EN adds hit_cnt_o / miss_cnt_o counters.
module riscv_nn_instr_l0_buffer #(
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  riscv_nn_instr_l0_buffer_if.slave bus,
  output logic                      busy_o
`ifdef NN_L0_PERF_CNT_EN
  ,
  output logic [31:0]               hit_cnt_o,
  output logic [31:0]               miss_cnt_o
`endif
);

  localparam int IDXW = $clog2(LINE_WORDS);
  localparam int OFF  = IDXW + 2;
  localparam int CW   = IDXW + 1;
  localparam int TAGW = 32 - OFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     line_q [LINE_WORDS];
  logic [TAGW-1:0] tag_q;
  logic [IDXW-1:0] idx_q;
  logic            line_valid_q;
  logic            flush_pend_q;
  logic [CW-1:0]   issue_cnt_q;
  logic [CW-1:0]   rx_cnt_q;
  logic            rvalid_q;
  logic [31:0]     rdata_q;

  logic            gnt;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic            hit;
  logic            rx_fire;
  logic            last_rx;
  logic            unused_addr_bits;

  assign req_tag          = bus.instr_addr_i[31:OFF];
  assign req_idx          = bus.instr_addr_i[OFF-1:2];
  assign unused_addr_bits = ^bus.instr_addr_i[1:0];

  assign hit     = line_valid_q && (req_tag == tag_q) && !flush_i;
  assign rx_fire = (state_q == REFILL) && bus.mem_rvalid_i;
  assign last_rx = rx_fire && (rx_cnt_q == CW'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt      = 1'b0;
    mem_req  = 1'b0;
    mem_addr = 32'd0;
    case (state_q)
      IDLE: begin
        gnt = bus.instr_req_i;
        if (bus.instr_req_i && !hit) begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req = (issue_cnt_q != CW'(LINE_WORDS));
        if (mem_req) begin
          mem_addr = {tag_q, issue_cnt_q[IDXW-1:0], 2'b00};
        end
        if (last_rx) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q        <= '0;
      idx_q        <= '0;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      issue_cnt_q  <= '0;
      rx_cnt_q     <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            line_valid_q <= 1'b0;
          end
          if (bus.instr_req_i) begin
            if (hit) begin
              rdata_q  <= line_q[req_idx];
              rvalid_q <= 1'b1;
            end else begin
              tag_q        <= req_tag;
              idx_q        <= req_idx;
              line_valid_q <= 1'b0;
              issue_cnt_q  <= '0;
              rx_cnt_q     <= '0;
            end
          end
        end
        REFILL: begin
          if (flush_i) begin
            flush_pend_q <= 1'b1;
          end
          if (mem_req && bus.mem_gnt_i) begin
            issue_cnt_q <= issue_cnt_q + CW'(1);
          end
          if (rx_fire) begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
          // The requested word may be the one arriving this very cycle.
          if (last_rx) begin
            line_valid_q <= !flush_pend_q && !flush_i;
            flush_pend_q <= 1'b0;
            rvalid_q     <= 1'b1;
            rdata_q      <= (idx_q == IDXW'(LINE_WORDS - 1)) ? bus.mem_rdata_i : line_q[idx_q];
          end
        end
        RESP: begin
          if (flush_i) begin
            line_valid_q <= 1'b0;
          end
        end
        default: begin
          line_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Line storage needs no reset: line_valid_q guards every read.
  always_ff @(posedge clk) begin
    if (rx_fire) begin
      line_q[rx_cnt_q[IDXW-1:0]] <= bus.mem_rdata_i;
    end
  end

  assign bus.instr_gnt_o    = gnt;
  assign bus.instr_rvalid_o = rvalid_q;
  assign bus.instr_rdata_o  = rdata_q;
  assign bus.mem_req_o      = mem_req;
  assign bus.mem_addr_o     = mem_addr;
  assign busy_o             = (state_q != IDLE) || rvalid_q;

`ifdef NN_L0_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else if (state_q == IDLE && bus.instr_req_i) begin
      if (hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end else begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_nn_instr_l0_buffer.sv
// tb/tb_riscv_nn_instr_l0_buffer.sv - directed self-checking bench for riscv_nn_instr_l0_buffer
module tb_riscv_nn_instr_l0_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        busy;
  logic        gnt_en;
`ifdef NN_L0_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  riscv_nn_instr_l0_buffer_if bus ();

  riscv_nn_instr_l0_buffer #(.LINE_WORDS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus),
    .busy_o  (busy)
`ifdef NN_L0_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory model: word at byte address A reads as {16'hC0DE, A[15:0]}.
  logic [31:0] pend[$];
  logic [31:0] log_q[$];
  int          rv_seen = 0;

  assign bus.mem_gnt_i = gnt_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (bus.mem_rvalid_i && pend.size() > 0) begin
        void'(pend.pop_front());
        rv_seen++;
      end
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        pend.push_back(bus.mem_addr_o);
        log_q.push_back(bus.mem_addr_o);
      end
    end
  end

  always @(negedge clk) begin
    bus.mem_rvalid_i = (pend.size() > 0);
    bus.mem_rdata_i  = (pend.size() > 0) ? {16'hC0DE, pend[0][15:0]} : 32'd0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a);
    step();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = a;
    #1;
    chk("gnt", {31'd0, bus.instr_gnt_o}, 32'd1);
  endtask

  task automatic await_rsp(output int lat, output logic [31:0] d);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      bus.instr_req_i = 1'b0;
      lat++;
      if (bus.instr_rvalid_o) break;
    end
    d = bus.instr_rdata_o;
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (log_q.size() > i) ? log_q[i] : 32'hDEAD_DEAD;
  endfunction

  int          lat;
  int          lb;
  int          rb;
  logic [31:0] d;

  initial begin
    rst              = 1'b1;
    flush            = 1'b0;
    gnt_en           = 1'b1;
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", {31'd0, bus.instr_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'd0, bus.instr_rvalid_o}, 32'd0);
    chk("rst_rdata", bus.instr_rdata_o, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // T1: cold miss refills 0x100..0x10C
    lb = log_q.size();
    issue(32'h100);
    await_rsp(lat, d);
    chk("t1_lat", lat, 32'd6);
    chk("t1_data", d, 32'hC0DE0100);
    chk("t1_nreq", log_q.size() - lb, 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", log_at(lb + i), 32'h100 + 32'(4 * i));
    step();
    chk("t1_pulse", {31'd0, bus.instr_rvalid_o}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
`ifdef NN_L0_PERF_CNT_EN
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    chk("t1_hit_cnt", hit_cnt, 32'd0);
`endif

    // T2: hit with low address bits set
    lb = log_q.size();
    issue(32'h10A);
    await_rsp(lat, d);
    chk("t2_lat", lat, 32'd1);
    chk("t2_data", d, 32'hC0DE0108);
    chk("t2_nreq", log_q.size() - lb, 32'd0);

    // T3: back-to-back hits, grant overlapping previous rvalid
    step();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h104;
    #1 chk("t3_gnt0", {31'd0, bus.instr_gnt_o}, 32'd1);
    step();
    chk("t3_rv0", {31'd0, bus.instr_rvalid_o}, 32'd1);
    chk("t3_d0", bus.instr_rdata_o, 32'hC0DE0104);
    chk("t3_mreq0", {31'd0, bus.mem_req_o}, 32'd0);
    bus.instr_addr_i = 32'h108;
    #1 chk("t3_gnt1", {31'd0, bus.instr_gnt_o}, 32'd1);
    step();
    chk("t3_rv1", {31'd0, bus.instr_rvalid_o}, 32'd1);
    chk("t3_d1", bus.instr_rdata_o, 32'hC0DE0108);
    bus.instr_addr_i = 32'h10C;
    step();
    chk("t3_rv2", {31'd0, bus.instr_rvalid_o}, 32'd1);
    chk("t3_d2", bus.instr_rdata_o, 32'hC0DE010C);
    chk("t3_mreq2", {31'd0, bus.mem_req_o}, 32'd0);
    bus.instr_req_i = 1'b0;
    step();
    chk("t3_idle", {31'd0, bus.instr_rvalid_o}, 32'd0);
`ifdef NN_L0_PERF_CNT_EN
    chk("t3_miss_cnt", miss_cnt, 32'd1);
    chk("t3_hit_cnt", hit_cnt, 32'd4);
`endif

    // T4: miss 0x200 with memory grant withheld 3 cycles
    gnt_en = 1'b0;
    lb = log_q.size();
    rb = rv_seen;
    issue(32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      bus.instr_req_i = 1'b0;
      chk("t4_mreq_hold", {31'd0, bus.mem_req_o}, 32'd1);
      chk("t4_maddr_hold", bus.mem_addr_o, 32'h200);
      chk("t4_busy", {31'd0, busy}, 32'd1);
    end
    gnt_en = 1'b1;

    // T5: flush coincident with the 2nd memory response
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.mem_rvalid_i && rv_seen == rb + 1) break;
    end
    chk("t5_flush_window", rv_seen, rb + 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    await_rsp(lat, d);
    chk("t5_data", d, 32'hC0DE0200);
    for (int i = 0; i < 4; i++) chk("t4_addr", log_at(lb + i), 32'h200 + 32'(4 * i));

    lb = log_q.size();
    issue(32'h204);
    await_rsp(lat, d);
    chk("t5_refetch_lat", lat, 32'd6);
    chk("t5_refetch_data", d, 32'hC0DE0204);
    chk("t5_nreq", log_q.size() - lb, 32'd4);
    for (int i = 0; i < 4; i++) chk("t5_addr", log_at(lb + i), 32'h200 + 32'(4 * i));

    issue(32'h20C);
    await_rsp(lat, d);
    chk("t5_hit_lat", lat, 32'd1);
    chk("t5_hit_data", d, 32'hC0DE020C);

    // Flush while idle invalidates the line
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue(32'h208);
    await_rsp(lat, d);
    chk("idle_flush_lat", lat, 32'd6);
    chk("idle_flush_data", d, 32'hC0DE0208);

    // Reset in the middle of a refill
    issue(32'h400);
    step();
    bus.instr_req_i = 1'b0;
    step();
    chk("mid_mreq", {31'd0, bus.mem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_mreq", {31'd0, bus.mem_req_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rvalid", {31'd0, bus.instr_rvalid_o}, 32'd0);
`ifdef NN_L0_PERF_CNT_EN
    chk("t6_rst_hit_cnt", hit_cnt, 32'd0);
    chk("t6_rst_miss_cnt", miss_cnt, 32'd0);
`endif
    step();
    rst = 1'b0;
    issue(32'h404);
    await_rsp(lat, d);
    chk("post_rst_lat", lat, 32'd6);
    chk("post_rst_data", d, 32'hC0DE0404);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
